// File: rtl/acc_feed_ctrl.sv
// acc_feed_ctrl: FIFO-buffered operand feeder that clears the accumulator before it would exceed LIMIT
module acc_feed_ctrl #(
  parameter int DATA_W     = 4,
  parameter int ACC_W      = 5,
  parameter int DEPTH      = 4,
  parameter int LIMIT      = 31,
  parameter int CLR_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [ACC_W-1:0]  acc,
  output logic [DATA_W-1:0] op_out,
  output logic              acc_clr,
  output logic              busy,
  output logic [7:0]        wrap_cnt,
  output logic              sync_err
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int CCW = CLR_CYCLES > 1 ? $clog2(CLR_CYCLES) : 1;
  typedef enum logic [1:0] {CLEAR, IDLE, FEED} state_t;
  state_t state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic [CCW-1:0] clr_cnt;
  logic [ACC_W-1:0] shadow, shadow_d;
  logic [ACC_W:0] sum;
  logic [DATA_W-1:0] head;
  logic empty, fits, push, pop, from_feed, clr_q;
  assign head     = mem[rp];
  assign empty    = count == '0;
  assign in_ready = count != CW'(DEPTH);
  assign sum      = {1'b0, shadow} + (ACC_W+1)'(head);
  assign fits     = sum <= (ACC_W+1)'(LIMIT);
  assign push     = in_valid && in_ready;
  assign pop      = state == FEED && !empty && fits;
  assign busy     = !(state == IDLE && empty);
  always_ff @(posedge clk)
    if (push) mem[wp] <= in_data;
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      op_out    <= '0;
      acc_clr   <= 1'b1;
      wrap_cnt  <= '0;
      sync_err  <= 1'b0;
      shadow    <= '0;
      shadow_d  <= '0;
      state     <= CLEAR;
      clr_cnt   <= '0;
      from_feed <= 1'b0;
      clr_q     <= 1'b1;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count    <= count + CW'(push) - CW'(pop);
      shadow_d <= shadow;
      clr_q    <= acc_clr;
      // acc lags op_out by one edge, so it is compared against the delayed shadow
      if (!acc_clr && !clr_q && acc != shadow_d) sync_err <= 1'b1;
      case (state)
        CLEAR: begin
          op_out <= '0;
          shadow <= '0;
          if (clr_cnt == CCW'(CLR_CYCLES - 1)) begin
            acc_clr   <= 1'b0;
            state     <= IDLE;
            from_feed <= 1'b0;
            if (from_feed && wrap_cnt != 8'hff) wrap_cnt <= wrap_cnt + 8'd1;
          end else clr_cnt <= clr_cnt + 1'b1;
        end
        IDLE: begin
          op_out <= '0;
          if (!empty) state <= FEED;
        end
        default: begin
          if (empty) begin
            op_out <= '0;
            state  <= IDLE;
          end else if (fits) begin
            op_out <= head;
            shadow <= sum[ACC_W-1:0];
          end else begin
            op_out    <= '0;
            acc_clr   <= 1'b1;
            clr_cnt   <= '0;
            from_feed <= 1'b1;
            state     <= CLEAR;
          end
        end
      endcase
    end
  end
endmodule
